// File: rtl/gray_pkg.sv
// Shared types and defaults for the Gray-code conversion arbiter.
// Holds the two-state output FSM encoding and the default requester count and code width.
package gray_pkg;

  localparam int GRAY_N_DEFAULT = 4;
  localparam int GRAY_W_DEFAULT = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } gray_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from (last_i+1) mod N upward
// and returns the first asserted request as a one-hot vector and as an index.
module rr_pick
  import gray_pkg::*;
#(
  parameter int N = GRAY_N_DEFAULT
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   last_i,
  output logic [N-1:0] winner_o,
  output logic [2:0]   index_o
);

  logic [3:0] cand;
  logic       found;

  always_comb begin
    winner_o = '0;
    index_o  = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      // last_i < N, so one subtraction is enough to wrap the candidate.
      cand = {1'b0, last_i} + 4'(k);
      if (cand >= 4'(N)) cand = cand - 4'(N);
      for (int j = 0; j < N; j++) begin
        if (!found && req_i[j] && (cand == 4'(j))) begin
          winner_o[j] = 1'b1;
          index_o     = 3'(j);
          found       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbitrated binary-to-Gray converter with a one-entry output register.
// Optional handshake counter output conv_count is enabled by GRAY_CONV_ARBITER_STATS_EN.
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter int N = GRAY_N_DEFAULT,
  parameter int W = GRAY_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] bin_in,
  output logic [N-1:0]   gnt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   gray_out,
  output logic [2:0]     out_id
`ifdef GRAY_CONV_ARBITER_STATS_EN
  ,
  output logic [15:0]    conv_count
`endif
);

  gray_state_e  state_q, state_d;
  logic [2:0]   last_q;
  logic [W-1:0] gray_q;
  logic [2:0]   id_q;

  logic [N-1:0] winner;
  logic [2:0]   win_idx;
  logic         load;
  logic [W-1:0] bin_sel;
  logic [W-1:0] gray_d;

  rr_pick #(.N(N)) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (winner),
    .index_o  (win_idx)
  );

  // Loading while FULL is only legal when the current result drains this edge.
  assign load = !rst && (|req) && ((state_q == EMPTY) || out_ready);

  always_comb begin
    bin_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (winner[i]) bin_sel = bin_sel | bin_in[i*W +: W];
    end
  end

  // Slice index 0 is the MSB, i.e. bit W-1 of the packed vector.
  for (genvar gi = 0; gi < W; gi++) begin : g_gray
    if (gi == 0) begin : g_msb
      assign gray_d[W-1] = bin_sel[W-1];
    end else begin : g_xor
      assign gray_d[W-1-gi] = bin_sel[W-gi] ^ bin_sel[W-1-gi];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (out_ready && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
    gnt       = load ? winner : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= '0;
      id_q   <= '0;
      last_q <= 3'(N - 1);
    end else if (load) begin
      gray_q <= gray_d;
      id_q   <= win_idx;
      last_q <= win_idx;
    end
  end

  assign gray_out = gray_q;
  assign out_id   = id_q;

`ifdef GRAY_CONV_ARBITER_STATS_EN
  logic [15:0] conv_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_count_q <= '0;
    end else if (out_valid && out_ready && (conv_count_q != 16'hFFFF)) begin
      conv_count_q <= conv_count_q + 16'd1;
    end
  end

  assign conv_count = conv_count_q;
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model; the conv_count test runs when GRAY_CONV_ARBITER_STATS_EN is defined.
module tb_gray_conv_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] bin_in;
  logic [N-1:0]   gnt;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   gray_out;
  logic [2:0]     out_id;
`ifdef GRAY_CONV_ARBITER_STATS_EN
  logic [15:0]    conv_count;
`endif

  gray_conv_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bin_in    (bin_in),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gray_out  (gray_out),
    .out_id    (out_id)
`ifdef GRAY_CONV_ARBITER_STATS_EN
    ,
    .conv_count(conv_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level reference state
  bit          m_full;
  logic [W-1:0] m_gray;
  int          m_id;
  int          m_last;
  int          m_hs;

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic int model_winner();
    if (rst || (req == '0) || (m_full && !out_ready)) return -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    int w;
    g = '0;
    w = model_winner();
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  task automatic set_slice(input int i, input logic [W-1:0] v);
    bin_in[i*W +: W] = v;
  endtask

  // Advance one clock and update the model; returns #1 after the edge.
  task automatic tick();
    int w;
    logic [W-1:0] op;
    w  = model_winner();
    op = (w >= 0) ? bin_in[w*W +: W] : '0;
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_gray = '0; m_id = 0; m_last = N - 1; m_hs = 0;
    end else begin
      if (m_full && out_ready && m_hs < 65535) m_hs++;
      if (w >= 0) begin
        m_full = 1; m_gray = to_gray(op); m_id = w; m_last = w;
      end else if (m_full && out_ready) begin
        m_full = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; out_ready = 1'b0; bin_in = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; out_ready = 1'b1; bin_in = '1;
    #1;
    n_checks++;
    if (gnt !== '0) $display("FAIL reset_gnt: got %b want %b", gnt, 4'b0000); else n_pass++;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || gray_out !== '0 || out_id !== 3'd0)
      $display("FAIL reset_state: got v=%b g=%b id=%0d want v=0 g=0000 id=0", out_valid, gray_out, out_id);
    else n_pass++;
    $display("txn reset: v=%b g=%b id=%0d", out_valid, gray_out, out_id);
    rst = 1'b0; req = '0;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; out_ready = 1'b1; set_slice(0, 4'b0110);
    #1;
    n_checks++;
    if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", gnt); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL single_latency: got valid=%b want 0", out_valid); else n_pass++;
    tick();
    req = '0;
    n_checks++;
    if (out_valid !== 1'b1 || gray_out !== 4'b0101 || out_id !== 3'd0)
      $display("FAIL single_result: got v=%b g=%b id=%0d want v=1 g=0101 id=0", out_valid, gray_out, out_id);
    else n_pass++;
    $display("txn single: g=%b id=%0d", gray_out, out_id);
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL single_drain: got valid=%b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_g [5];
    exp_g = '{4'b1000, 4'b1100, 4'b0010, 4'b0000, 4'b1000};
    do_reset();
    set_slice(0, 4'b1111); set_slice(1, 4'b1000); set_slice(2, 4'b0011); set_slice(3, 4'b0000);
    req = 4'b1111; out_ready = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      logic [N-1:0] eg;
      eg = '0; eg[c % N] = 1'b1;
      n_checks++;
      if (gnt !== eg) $display("FAIL rr_gnt%0d: got %b want %b", c, gnt, eg); else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || gray_out !== exp_g[c] || out_id !== 3'(c % N))
        $display("FAIL rr_result%0d: got v=%b g=%b id=%0d want v=1 g=%b id=%0d",
                 c, out_valid, gray_out, out_id, exp_g[c], c % N);
      else n_pass++;
      $display("txn rr: cycle %0d g=%b id=%0d", c, gray_out, out_id);
    end
    req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    do_reset();
    req = 4'b0001; out_ready = 1'b0; set_slice(0, 4'b1011); set_slice(1, 4'b0111);
    tick();
    held = gray_out;
    req = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (gnt !== '0) $display("FAIL bp_gnt%0d: got %b want 0000", c, gnt); else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || gray_out !== held || gray_out !== to_gray(4'b1011) || out_id !== 3'd0)
        $display("FAIL bp_hold%0d: got v=%b g=%b id=%0d want v=1 g=%b id=0", c, out_valid, gray_out, out_id, to_gray(4'b1011));
      else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (gnt !== 4'b0010) $display("FAIL bp_release_gnt: got %b want 0010", gnt); else n_pass++;
    tick();
    req = '0;
    n_checks++;
    if (out_valid !== 1'b1 || gray_out !== 4'b0100 || out_id !== 3'd1)
      $display("FAIL bp_release_result: got v=%b g=%b id=%0d want v=1 g=0100 id=1", out_valid, gray_out, out_id);
    else n_pass++;
    $display("txn backpressure: g=%b id=%0d", gray_out, out_id);
    tick();
  endtask

  task automatic test_midreset();
    do_reset();
    req = 4'b0100; out_ready = 1'b0; set_slice(2, 4'b1101);
    tick();
    req = 4'b1001; rst = 1'b1;
    #1;
    n_checks++;
    if (gnt !== '0) $display("FAIL midrst_gnt_in_reset: got %b want 0000", gnt); else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || gray_out !== '0 || out_id !== 3'd0)
      $display("FAIL midrst_state: got v=%b g=%b id=%0d want v=0 g=0000 id=0", out_valid, gray_out, out_id);
    else n_pass++;
    n_checks++;
    if (gnt !== 4'b0001) $display("FAIL midrst_priority: got %b want 0001", gnt); else n_pass++;
    $display("txn midreset: gnt=%b", gnt);
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_exhaustive();
    logic [W-1:0] prev;
    do_reset();
    req = 4'b0100; out_ready = 1'b1;
    prev = '0;
    for (int v = 0; v < 16; v++) begin
      set_slice(2, 4'(v));
      #1;
      n_checks++;
      if (gnt !== 4'b0100) $display("FAIL exh_gnt%0d: got %b want 0100", v, gnt); else n_pass++;
      tick();
      n_checks++;
      if (gray_out !== m_gray || out_id !== 3'd2 || out_valid !== 1'b1)
        $display("FAIL exh_result%0d: got g=%b id=%0d want g=%b id=2", v, gray_out, out_id, m_gray);
      else n_pass++;
      if (v > 0) begin
        n_checks++;
        if ($countones(gray_out ^ prev) != 1)
          $display("FAIL exh_adjacent%0d: got %b after %b want one-bit change", v, gray_out, prev);
        else n_pass++;
      end
      $display("txn exhaustive: bin=%0d g=%b", v, gray_out);
      prev = gray_out;
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 60; c++) begin
      logic [N-1:0] eg;
      rst       = ($urandom_range(0, 19) == 0);
      req       = N'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      bin_in    = (N*W)'($urandom);
      #1;
      eg = model_gnt();
      n_checks++;
      if (gnt !== eg) $display("FAIL rand_gnt%0d: got %b want %b", c, gnt, eg); else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== m_full || (m_full && (gray_out !== m_gray || out_id !== 3'(m_id))))
        $display("FAIL rand_out%0d: got v=%b g=%b id=%0d want v=%b g=%b id=%0d",
                 c, out_valid, gray_out, out_id, m_full, m_gray, m_id);
      else n_pass++;
      $display("txn random %0d: rst=%b gnt=%b v=%b g=%b id=%0d", c, rst, eg, out_valid, gray_out, out_id);
    end
    rst = 1'b0; req = '0;
    tick();
  endtask

`ifdef GRAY_CONV_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    n_checks++;
    if (conv_count !== 16'd0) $display("FAIL stats_reset: got %0d want 0", conv_count); else n_pass++;
    req = 4'b0001; out_ready = 1'b1; set_slice(0, 4'b0011);
    repeat (21) tick();
    n_checks++;
    if (conv_count !== 16'd20 || m_hs != 20) $display("FAIL stats_20: got %0d want 20", conv_count); else n_pass++;
    $display("txn stats: count=%0d", conv_count);
    repeat (70000) tick();
    n_checks++;
    if (conv_count !== 16'hFFFF) $display("FAIL stats_sat: got %h want ffff", conv_count); else n_pass++;
    $display("txn stats: count=%h", conv_count);
    req = '0;
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; out_ready = 1'b0; bin_in = '0;
    m_full = 0; m_gray = '0; m_id = 0; m_last = N - 1; m_hs = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_midreset();
    test_exhaustive();
    test_random();
`ifdef GRAY_CONV_ARBITER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning number of requesters (legal 2..8).
REQ-002 The block SHALL have parameter W, default 4, meaning code width in bits (legal 2..16).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req  input  N  per-requester conversion request, level, held until granted.
REQ-006 The block SHALL have port bin_in  input  N*W  packed binary operands; requester i occupies slice i; within a slice the lowest index is the MSB.
REQ-007 The block SHALL have port gnt  output  N  one-hot grant, combinational, high in the cycle its operand is captured.
REQ-008 The block SHALL have port out_valid  output  1  gray_out/out_id hold a result.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts the result when out_valid and out_ready are both high at a rising edge.
REQ-010 The block SHALL have port gray_out  output  W  registered Gray code; lowest index is the MSB.
REQ-011 The block SHALL have port out_id  output  3  index of the requester that owns gray_out.

Function
REQ-012 gray_out SHALL equal g[0]=b[0], g[k]=b[k-1] XOR b[k] for k=1..W-1, where b is the granted operand.
REQ-013 The FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 A load SHALL occur when any req is high and (state=EMPTY, or state=FULL with out_ready=1).
REQ-015 On load, the result SHALL be registered and state SHALL become FULL; out_valid SHALL rise on the cycle after gnt (latency 1).
REQ-016 In FULL with out_ready=1 and no req, state SHALL return to EMPTY.
REQ-017 In FULL with out_ready=0, gnt SHALL be all zero and gray_out/out_id SHALL stay stable.
REQ-018 Arbitration SHALL be round-robin: the search starts at (last+1) mod N, and the first asserted req wins.
REQ-019 last SHALL update to the winner only on load.
REQ-020 Simultaneous drain and load SHALL sustain one result per cycle with no bubble.
REQ-021 gnt SHALL never have more than one bit set, and SHALL be zero when no load occurs.
REQ-022 A requester SHALL see gnt at most once per load; after seeing gnt high it deasserts or presents a new operand.

Reset
REQ-023 While rst=1 at an edge: state=EMPTY, out_valid=0, gray_out=0, out_id=0, last=N-1, so requester 0 has priority first.
REQ-024 Reset asserted while FULL SHALL discard the pending result without a handshake.
REQ-025 gnt SHALL be all zero while rst=1.

Configuration
REQ-026 Macro GRAY_CONV_ARBITER_STATS_EN SHALL, when defined, add output conv_count (16 bits) that counts completed handshakes (out_valid AND out_ready), saturates at 16'hFFFF, and clears on reset.
REQ-027 Without GRAY_CONV_ARBITER_STATS_EN, port conv_count and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 The shared package gray_pkg SHALL hold the FSM state enum (EMPTY, FULL) and the defaults for N and W.
REQ-029 The combinational round-robin picker SHALL be the sub-module rr_pick (inputs req and last; outputs one-hot winner and index).
REQ-030 The Gray conversion SHALL be inline XOR logic, with no additional sub-module.

Verification
REQ-031 Single request: req=0001, bin slice0=0110, out_ready=1 -> gnt=0001 that cycle, next cycle out_valid=1, gray_out=0101, out_id=0.
REQ-032 Round-robin fairness: req=1111 held, slices 1111/1000/0011/0000 for requesters 0/1/2/3, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; gray_out 1000,1100,0010,0000.
REQ-033 Backpressure: out_ready=0 for 5 cycles while FULL and req=0010 -> gnt=0 and gray_out stable; out_ready=1 -> same-cycle drain plus load of requester 1.
REQ-034 Mid-operation reset: rst=1 while FULL -> next cycle out_valid=0, gray_out=0, and the following arbitration favours requester 0 over requester 3 with req=1001.
REQ-035 Stats (macro defined): 20 handshakes -> conv_count=20; force 70000 handshakes -> conv_count=16'hFFFF.
REQ-036 Exhaustive code check: all 16 W=4 operands through requester 2 -> adjacent outputs differ by exactly one bit; out_id=2 on every result.
